// File: rtl/control_sequencer_if.sv
// Instruction-fetch bus between the control sequencer (master) and instruction memory (slave).
interface control_sequencer_if;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic       mem_ack;
    logic [7:0] mem_data;

    modport master (output mem_req, mem_addr, input mem_ack, mem_data);
    modport slave  (input mem_req, mem_addr, output mem_ack, mem_data);
endinterface

// File: rtl/control_sequencer.sv
// Fetch/decode/execute sequencer for the Mega-8 datapath; owns the PC and IR.
// Optional single-step PAUSE state is enabled by CONTROL_SEQUENCER_SINGLE_STEP_EN.
module control_sequencer #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic                clk,
    input  logic                rst,
    control_sequencer_if.master mem,
    input  logic                run,
`ifdef CONTROL_SEQUENCER_SINGLE_STEP_EN
    input  logic                step,
`endif
    output logic [3:0]          alu_sel,
    output logic [3:0]          rf_addr,
    output logic                acc_we,
    output logic                flags_we,
    output logic                halted,
    output logic                illegal
);
    typedef enum logic [2:0] {
        S_START, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT, S_PAUSE
    } state_t;

`ifdef CONTROL_SEQUENCER_SINGLE_STEP_EN
    localparam state_t S_AFTER = S_PAUSE;
`else
    localparam state_t S_AFTER = S_FETCH;
`endif

    state_t     state, state_nxt;
    logic [7:0] pc;
    logic [7:0] ir;
    logic       is_alu;

    assign is_alu = (ir[7:4] != 4'hF);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_START;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_START:  state_nxt = S_FETCH;
            S_FETCH:  if (mem.mem_ack) state_nxt = S_DECODE;
            S_DECODE: begin
                if (is_alu)               state_nxt = S_EXEC;
                else if (ir[3:0] == 4'h1) state_nxt = S_HALT;
                else                      state_nxt = S_AFTER;
            end
            S_EXEC:   state_nxt = S_WB;
            S_WB:     state_nxt = S_AFTER;
            S_HALT:   if (run) state_nxt = S_FETCH;
`ifdef CONTROL_SEQUENCER_SINGLE_STEP_EN
            S_PAUSE:  if (step) state_nxt = S_FETCH;
`endif
            default:  state_nxt = S_START;
        endcase
    end

    always_comb begin
        mem.mem_req  = (state == S_FETCH);
        mem.mem_addr = pc;
        acc_we       = (state == S_WB);
        flags_we     = (state == S_WB);
        halted       = (state == S_HALT);
    end

    // alu_sel/rf_addr latch on the way into EXEC so they hold through WB and after
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc      <= RESET_PC;
            ir      <= 8'h00;
            alu_sel <= 4'h0;
            rf_addr <= 4'h0;
            illegal <= 1'b0;
        end else begin
            if (state == S_FETCH && mem.mem_ack) begin
                ir <= mem.mem_data;
                pc <= pc + 8'h01;
            end
            if (state == S_DECODE) begin
                if (is_alu) begin
                    alu_sel <= ir[7:4];
                    rf_addr <= ir[3:0];
                end else if (ir[3:1] != 3'b000) begin
                    illegal <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_control_sequencer.sv
// Randomized instruction-level bench for control_sequencer with an instruction-trace reference model.
module tb_control_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst2 = 1'b1;
    logic run = 1'b0;
    logic run2 = 1'b0;
    always #5 clk = ~clk;

    control_sequencer_if bus();
    control_sequencer_if bus2();

    logic [3:0] alu_sel, rf_addr, alu_sel2, rf_addr2;
    logic       acc_we, flags_we, halted, illegal;
    logic       acc_we2, flags_we2, halted2, illegal2;

    control_sequencer #(.RESET_PC(8'h00)) dut (
        .clk(clk), .rst(rst), .mem(bus), .run(run),
`ifdef CONTROL_SEQUENCER_SINGLE_STEP_EN
        .step(1'b1),
`endif
        .alu_sel(alu_sel), .rf_addr(rf_addr), .acc_we(acc_we),
        .flags_we(flags_we), .halted(halted), .illegal(illegal)
    );

    control_sequencer #(.RESET_PC(8'hFF)) dut2 (
        .clk(clk), .rst(rst2), .mem(bus2), .run(run2),
`ifdef CONTROL_SEQUENCER_SINGLE_STEP_EN
        .step(1'b1),
`endif
        .alu_sel(alu_sel2), .rf_addr(rf_addr2), .acc_we(acc_we2),
        .flags_we(flags_we2), .halted(halted2), .illegal(illegal2)
    );

    // zero-wait memory that always returns 0x05
    assign bus2.mem_ack  = bus2.mem_req;
    assign bus2.mem_data = 8'h05;

    int checks = 0;
    int failures = 0;

    logic [7:0] rom [256];
    logic [7:0] pc;
    logic       ilg;
    logic [3:0] lsel, lrf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    // one clock cycle: check outputs against the model, then drive inputs
    task automatic tick(input string ph, input logic e_req, input logic e_we, input logic e_halt,
                        input logic in_ack, input logic in_run);
        @(negedge clk);
        chk({ph, ".req"}, bus.mem_req, e_req);
        chk({ph, ".acc_we"}, acc_we, e_we);
        chk({ph, ".flags_we"}, flags_we, e_we);
        chk({ph, ".halted"}, halted, e_halt);
        chk({ph, ".illegal"}, illegal, ilg);
        chk({ph, ".alu_sel"}, alu_sel, lsel);
        chk({ph, ".rf_addr"}, rf_addr, lrf);
        if (e_req) chk({ph, ".addr"}, bus.mem_addr, pc);
        bus.mem_ack  = in_ack;
        bus.mem_data = rom[pc];
        run          = in_run;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".req"}, bus.mem_req, 0);
        chk({tag, ".alu_sel"}, alu_sel, 0);
        chk({tag, ".rf_addr"}, rf_addr, 0);
        chk({tag, ".acc_we"}, acc_we, 0);
        chk({tag, ".flags_we"}, flags_we, 0);
        chk({tag, ".halted"}, halted, 0);
        chk({tag, ".illegal"}, illegal, 0);
    endtask

    initial begin
        logic [7:0] ins;
        int w, k, r;
        bit did_rst = 0;

        for (int i = 0; i < 256; i++) begin
            r = $urandom_range(0, 9);
            if (r < 7)       rom[i] = {4'($urandom_range(0, 14)), 4'($urandom)};
            else if (r == 7) rom[i] = 8'hF0;
            else if (r == 8) rom[i] = 8'hF1;
            else             rom[i] = {4'hF, 4'($urandom_range(2, 15))};
        end
        rom[0] = 8'h23;
        rom[1] = 8'hF7;
        rom[2] = 8'hF1;
        rom[3] = 8'h5A;
        bus.mem_ack  = 1'b0;
        bus.mem_data = 8'h00;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        chk("reset.addr", bus.mem_addr, 8'h00);
        chk("reset2.addr", bus2.mem_addr, 8'hFF);

        // RESET_PC=0xFF instance: fetch 0x05 at 0xFF, next fetch wraps to 0x00
        rst2 = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) begin
                chk("wrap.req1", bus2.mem_req, 1);
                chk("wrap.addr1", bus2.mem_addr, 8'hFF);
            end
            if (c == 3) chk("wrap.rf", rf_addr2, 4'h5);
            if (c == 4) chk("wrap.we", acc_we2, 1);
            if (c == 5) begin
                chk("wrap.req2", bus2.mem_req, 1);
                chk("wrap.addr2", bus2.mem_addr, 8'h00);
            end
        end

        rst = 1'b0;
        pc = 8'h00; ilg = 1'b0; lsel = 4'h0; lrf = 4'h0;

        for (int n = 0; n < 320; n++) begin
            w = (n == 0) ? 0 : (n == 1) ? 4 : $urandom_range(0, 2);
            for (int i = 0; i <= w; i++)
                tick("fetch", 1, 0, 0, (i == w), 1'($urandom_range(0, 1)));
            ins = rom[pc];
            pc  = pc + 8'h01;
            tick("decode", 0, 0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if (ins[7:4] != 4'hF) begin
                lsel = ins[7:4];
                lrf  = ins[3:0];
                tick("exec", 0, 0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                if (n >= 200 && !did_rst) begin
                    did_rst = 1;
                    #1 rst = 1'b1;
                    bus.mem_ack = 1'b0;
                    run = 1'b0;
                    #1 chk_reset_outputs("midrst");
                    chk("midrst.addr", bus.mem_addr, 8'h00);
                    @(negedge clk);
                    rst = 1'b0;
                    pc = 8'h00; ilg = 1'b0; lsel = 4'h0; lrf = 4'h0;
                    continue;
                end
                tick("wb", 0, 1, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end else if (ins[3:0] == 4'h1) begin
                k = (n == 2) ? 10 : $urandom_range(1, 6);
                for (int j = 0; j < k; j++)
                    tick("halt", 0, 0, 1, 1'($urandom_range(0, 1)), 1'b0);
                tick("halt_run", 0, 0, 1, 1'($urandom_range(0, 1)), 1'b1);
            end else if (ins[3:0] != 4'h0) begin
                ilg = 1'b1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
